// File: rtl/joy_db15_resp.sv
// DB15 joystick responder: presents two 16-bit joystick words to a host as a
// serial frame clocked by the host's joy_load/joy_clk strobes.
// Optional build macro JOY_DB15_RESP_FILTER_EN adds a 3-sample glitch filter
// on the synchronized host strobes.
module joy_db15_resp #(
  parameter int FRAME_BITS  = 32,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] joystick1,
  input  logic [15:0] joystick2,
  input  logic        joy_load,
  input  logic        joy_clk,
  output logic        joy_data,
  output logic        frame_done,
  output logic        link_active
);

  localparam int CW = $clog2(FRAME_BITS + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] LAST_BIT    = CW'(FRAME_BITS - 1);
  localparam logic [TW-1:0] TIMEOUT_MAX = TW'(TIMEOUT_CYC);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  state_t                 state, state_nxt;
  logic [FRAME_BITS-1:0]  shreg;
  logic [FRAME_BITS-1:0]  load_word;
  logic [31:0]            snap;
  logic [CW-1:0]          bit_cnt;
  logic [TW-1:0]          tcnt;

  logic load_s1, load_s2, clk_s1, clk_s2;
  logic load_level, clk_level;
  logic load_prev, clk_prev;
  logic load_low, load_rise, load_fall, clk_rise;
  logic activity, timeout;
  logic shift_en, done_hit;

  // Two-flop synchronizers for the asynchronous host strobes (idle high).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      load_s1 <= 1'b1;
      load_s2 <= 1'b1;
      clk_s1  <= 1'b1;
      clk_s2  <= 1'b1;
    end else begin
      load_s1 <= joy_load;
      load_s2 <= load_s1;
      clk_s1  <= joy_clk;
      clk_s2  <= clk_s1;
    end
  end

`ifdef JOY_DB15_RESP_FILTER_EN
  logic load_h1, load_h2, clk_h1, clk_h2;

  // History of the synchronized levels used by the stability filter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      load_h1 <= 1'b1;
      load_h2 <= 1'b1;
      clk_h1  <= 1'b1;
      clk_h2  <= 1'b1;
    end else begin
      load_h1 <= load_s2;
      load_h2 <= load_h1;
      clk_h1  <= clk_s2;
      clk_h2  <= clk_h1;
    end
  end

  // A level is accepted only once three consecutive samples agree;
  // otherwise the previously accepted level is held.
  always_comb begin
    load_level = load_prev;
    clk_level  = clk_prev;
    if ((load_s2 == load_h1) && (load_h1 == load_h2)) load_level = load_s2;
    if ((clk_s2 == clk_h1) && (clk_h1 == clk_h2))     clk_level  = clk_s2;
  end
`else
  // Unfiltered: the synchronized level is the accepted level.
  always_comb begin
    load_level = load_s2;
    clk_level  = clk_s2;
  end
`endif

  // Previous accepted levels for edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      load_prev <= 1'b1;
      clk_prev  <= 1'b1;
    end else begin
      load_prev <= load_level;
      clk_prev  <= clk_level;
    end
  end

  // Edge qualification; joy_clk edges are ignored while load is held low.
  always_comb begin
    load_low  = ~load_level;
    load_rise = load_level & ~load_prev;
    load_fall = ~load_level & load_prev;
    clk_rise  = clk_level & ~clk_prev & load_level;
    activity  = load_rise | load_fall | clk_rise;
    timeout   = (tcnt == TIMEOUT_MAX) & ~activity;
  end

  // Map the joystick words into the frame, joystick1 in the low bits.
  always_comb begin
    snap      = {joystick2, joystick1};
    load_word = '0;
    for (int unsigned i = 0; i < FRAME_BITS; i++) begin
      if (i < 32) load_word[i] = snap[i];
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic: load low overrides everything, then link timeout.
  always_comb begin
    state_nxt = state;
    shift_en  = 1'b0;
    done_hit  = 1'b0;
    if (load_low) begin
      state_nxt = LOAD;
    end else if (timeout) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        LOAD: begin
          if (load_rise) state_nxt = SHIFT;
        end
        SHIFT: begin
          if (clk_rise) begin
            shift_en = 1'b1;
            if (bit_cnt == LAST_BIT) begin
              state_nxt = DONE;
              done_hit  = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Shift register, bit counter and frame_done pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shreg      <= '0;
      bit_cnt    <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= done_hit;
      if (load_low) begin
        shreg   <= load_word;
        bit_cnt <= '0;
      end else if (shift_en) begin
        shreg   <= shreg >> 1;
        bit_cnt <= bit_cnt + CW'(1);
      end
    end
  end

  // Link watchdog: saturating idle counter restarted by any accepted edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tcnt        <= '0;
      link_active <= 1'b0;
    end else if (activity) begin
      tcnt        <= '0;
      link_active <= 1'b1;
    end else if (tcnt != TIMEOUT_MAX) begin
      tcnt <= tcnt + TW'(1);
    end else begin
      link_active <= 1'b0;
    end
  end

  // Serial output is active-low; idle and completed frames read as 1.
  always_comb begin
    case (state)
      IDLE, DONE: joy_data = 1'b1;
      default:    joy_data = ~shreg[0];
    endcase
  end

endmodule

// File: tb/tb_joy_db15_resp.sv
// Self-checking bench for joy_db15_resp (table vectors + corner sequences).
module tb_joy_db15_resp;

  localparam int FB = 32;
  localparam int TO = 100;
`ifdef JOY_DB15_RESP_FILTER_EN
  localparam int LAT = 5;
`else
  localparam int LAT = 3;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        joy_load = 1'b1;
  logic        joy_clk = 1'b0;
  logic [15:0] joystick1 = '0;
  logic [15:0] joystick2 = '0;
  logic        joy_data, frame_done, link_active;

  int total = 0;
  int bad = 0;
  int done_total = 0;

  typedef struct {
    logic [15:0] j1;
    logic [15:0] j2;
    int          n;
    logic        exp_data;
    int          exp_done;
  } vec_t;

  typedef struct {
    logic exp_data;
    int   exp_done;
  } exp_t;

  vec_t vecs[12];
  exp_t exp_q[$];

  joy_db15_resp #(.FRAME_BITS(FB), .TIMEOUT_CYC(TO)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .joystick1  (joystick1),
    .joystick2  (joystick2),
    .joy_load   (joy_load),
    .joy_clk    (joy_clk),
    .joy_data   (joy_data),
    .frame_done (frame_done),
    .link_active(link_active)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (frame_done) done_total++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic do_load(input logic [15:0] j1, input logic [15:0] j2);
    joystick1 = j1;
    joystick2 = j2;
    joy_load = 1'b0;
    repeat (10) tick();
    joy_load = 1'b1;
    repeat (LAT + 2) tick();
    joystick1 = 16'hDEAD;
    joystick2 = 16'hBEEF;
  endtask

  task automatic pulse();
    joy_clk = 1'b1;
    repeat (4) tick();
    joy_clk = 1'b0;
    repeat (6) tick();
  endtask

  initial begin
    int base;
    int k;
    exp_t e;

    vecs[0]  = '{16'h0001, 16'h0000,  0, 1'b0, 0};
    vecs[1]  = '{16'h0001, 16'h0000,  1, 1'b1, 0};
    vecs[2]  = '{16'h0004, 16'h0000,  2, 1'b0, 0};
    vecs[3]  = '{16'h0004, 16'h0000,  1, 1'b1, 0};
    vecs[4]  = '{16'h0000, 16'h0001, 16, 1'b0, 0};
    vecs[5]  = '{16'h0000, 16'h8000, 30, 1'b1, 0};
    vecs[6]  = '{16'h0000, 16'h8000, 31, 1'b0, 0};
    vecs[7]  = '{16'h0000, 16'h8000, 32, 1'b1, 1};
    vecs[8]  = '{16'hFFFF, 16'hFFFF, 31, 1'b0, 0};
    vecs[9]  = '{16'hFFFF, 16'hFFFF, 32, 1'b1, 1};
    vecs[10] = '{16'hA5A5, 16'h0000,  5, 1'b0, 0};
    vecs[11] = '{16'h0000, 16'h0000,  0, 1'b1, 0};

    // reset values
    repeat (3) tick();
    check("rst_data", joy_data, 1);
    check("rst_done", frame_done, 0);
    check("rst_link", link_active, 0);
    reset_n = 1'b1;
    repeat (3) tick();
    check("post_rst_link", link_active, 0);
    check("post_rst_data", joy_data, 1);

    // first bit and shift latency
    do_load(16'h0001, 16'h0000);
    check("first_bit", joy_data, 0);
    check("link_up", link_active, 1);
    joy_clk = 1'b1;
    repeat (LAT - 1) tick();
    check("lat_early", joy_data, 0);
    tick();
    check("lat_exact", joy_data, 1);
    repeat (3) tick();
    joy_clk = 1'b0;
    repeat (6) tick();

    // table vectors through the scoreboard
    for (int i = 0; i < 12; i++) begin
      do_load(vecs[i].j1, vecs[i].j2);
      base = done_total;
      exp_q.push_back('{vecs[i].exp_data, vecs[i].exp_done});
      for (int p = 0; p < vecs[i].n; p++) pulse();
      e = exp_q.pop_front();
      check($sformatf("vec%0d_data", i), joy_data, e.exp_data);
      check($sformatf("vec%0d_done", i), done_total - base, e.exp_done);
    end

    // saturation in DONE
    do_load(16'h0000, 16'h8000);
    for (int p = 0; p < 32; p++) pulse();
    base = done_total;
    pulse();
    pulse();
    check("sat_done", done_total - base, 0);
    check("sat_data", joy_data, 1);

    // abort mid-shift
    do_load(16'h0400, 16'h0000);
    for (int p = 0; p < 10; p++) pulse();
    check("pre_abort_data", joy_data, 0);
    base = done_total;
    joystick1 = 16'h0000;
    joystick2 = 16'h8000;
    joy_load = 1'b0;
    repeat (10) tick();
    check("abort_reload", joy_data, 1);
    joy_load = 1'b1;
    repeat (LAT + 2) tick();
    for (int p = 0; p < 31; p++) pulse();
    check("abort_bit31", joy_data, 0);
    check("abort_no_done", done_total - base, 0);
    pulse();
    check("abort_done", done_total - base, 1);
    check("abort_end_data", joy_data, 1);

    // link timeout
    do_load(16'h0003, 16'h0000);
    pulse();
    check("to_shift_data", joy_data, 0);
    check("to_link_pre", link_active, 1);
    repeat (85) tick();
    check("to_link_hold", link_active, 1);
    k = 0;
    while (link_active && k < 40) begin
      tick();
      k++;
    end
    check("to_link_drop", link_active, 0);
    check("to_idle_data", joy_data, 1);
    pulse();
    check("to_link_back", link_active, 1);
    check("to_idle_stays", joy_data, 1);

    // asynchronous reset mid-shift
    do_load(16'h0002, 16'h0000);
    pulse();
    check("rst_mid_pre", joy_data, 0);
    reset_n = 1'b0;
    #1;
    check("rst_mid_data", joy_data, 1);
    check("rst_mid_done", frame_done, 0);
    check("rst_mid_link", link_active, 0);
    #5;
    reset_n = 1'b1;
    tick();
    pulse();
    pulse();
    check("rst_discard", joy_data, 1);
    do_load(16'h0001, 16'h0000);
    check("rst_reload", joy_data, 0);

`ifdef JOY_DB15_RESP_FILTER_EN
    // glitch rejection and filtered latency
    joy_clk = 1'b1;
    repeat (2) tick();
    joy_clk = 1'b0;
    repeat (10) tick();
    check("glitch_rejected", joy_data, 0);
    joy_clk = 1'b1;
    repeat (4) tick();
    check("filt_early", joy_data, 0);
    tick();
    check("filt_lat5", joy_data, 1);
    repeat (5) tick();
    joy_clk = 1'b0;
    repeat (8) tick();
    check("filt_one_shift", joy_data, 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/joy_db15_resp.md
JOY_DB15_RESP -- requirements
Module: joy_db15_resp

Interface
REQ-001 SHALL have parameter FRAME_BITS, default 32, meaning number of serial bits per frame (joystick1 16 bits then joystick2 16 bits).
REQ-002 SHALL have parameter TIMEOUT_CYC, default 100000, meaning clk cycles without an accepted joy_clk or joy_load edge before link_active drops.
REQ-003 SHALL have port clk, input, 1 bit: system clock, 40-50 MHz; this is the block's only clock.
REQ-004 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port joystick1, input, 16 bits: player 1 buttons, active-high, layout FEDCBAUDLR in bits [9:0], bits [11:10] are L/S.
REQ-006 SHALL have port joystick2, input, 16 bits: player 2 buttons, same layout as joystick1.
REQ-007 SHALL have port joy_load, input, 1 bit: host parallel-load strobe, active-low, asynchronous to clk.
REQ-008 SHALL have port joy_clk, input, 1 bit: host shift clock, active on the rising edge, asynchronous to clk.
REQ-009 SHALL have port joy_data, output, 1 bit: serial data, active-low on the wire (0 = pressed).
REQ-010 SHALL have port frame_done, output, 1 bit: one-cycle pulse when the last frame bit is shifted past.
REQ-011 SHALL have port link_active, output, 1 bit: high while the host is clocking within TIMEOUT_CYC.

Function
REQ-012 SHALL pass joy_load and joy_clk through 2-flop synchronizers, then detect edges on the synchronized values.
REQ-013 SHALL implement states IDLE, LOAD, SHIFT and DONE.
REQ-014 SHALL, while synchronized joy_load is 0 (any state), copy {joystick2, joystick1} into a FRAME_BITS shift register every cycle, set the bit counter to 0 and enter LOAD.
REQ-015 SHALL, on the synchronized joy_load rising edge, move LOAD to SHIFT with the last-loaded snapshot frozen.
REQ-016 SHALL drive joy_data = ~shreg[0] in LOAD, SHIFT and DONE, so joystick1[0] is the first bit presented after load.
REQ-017 SHALL, in SHIFT on a synchronized joy_clk rising edge, shift the register right, fill the MSB with 0 (reads as idle 1 on the wire) and increment the counter.
REQ-018 SHALL have joy_data reflect a shift 3 clk cycles after the raw joy_clk rising edge (2 sync cycles + 1 register cycle).
REQ-019 SHALL enter DONE and pulse frame_done for exactly one cycle when the counter reaches FRAME_BITS.
REQ-020 SHALL drive joy_data = 1 in DONE, and leave the counter saturated there on further joy_clk edges.
REQ-021 SHALL ignore joy_clk edges while synchronized joy_load is 0 (load has priority).
REQ-022 SHALL treat joy_load falling mid-SHIFT as an abort: reload, counter = 0, no frame_done.
REQ-023 SHALL drive joy_data = 1 in IDLE.
REQ-024 SHALL restart a timeout counter on every accepted joy_clk or joy_load edge.
REQ-025 SHALL, when the timeout counter reaches TIMEOUT_CYC, deassert link_active and return to IDLE; link_active reasserts on the next accepted edge.
REQ-026 SHALL size the bit counter to clog2(FRAME_BITS+1) bits and the timeout counter to clog2(TIMEOUT_CYC+1) bits; neither SHALL wrap.

Reset
REQ-027 SHALL, while reset_n = 0, asynchronously force: state IDLE, shift register 0, counters 0, synchronizers 1, joy_data 1, frame_done 0, link_active 0.
REQ-028 SHALL, on reset mid-frame, discard the frame; the first valid output follows a new joy_load low.

Configuration
REQ-029 SHALL define macro JOY_DB15_RESP_FILTER_EN.
REQ-030 SHALL, when JOY_DB15_RESP_FILTER_EN is defined, accept a synchronized joy_clk/joy_load level only after it is stable for 2 further consecutive cycles, making REQ-018 latency 5 cycles; pulses shorter than 3 clk cycles SHALL be rejected.
REQ-031 SHALL, when JOY_DB15_RESP_FILTER_EN is undefined, omit the filter entirely: latency per REQ-018, and no minimum pulse width beyond the synchronizer.

Verification
REQ-032 Bench SHALL cover: joystick1=16'h0001, joystick2=0, load low 10 cycles then high -> joy_data=0 before the first clock; after 1 joy_clk edge -> joy_data=1.
REQ-033 Bench SHALL cover: joystick2=16'h8000, 32 joy_clk edges -> joy_data=0 only after the 31st edge; frame_done pulses once after the 32nd; joy_data=1 after that.
REQ-034 Bench SHALL cover: joy_load falling after 10 edges -> counter 0, no frame_done, joy_data = ~joystick1[0] of the new snapshot.
REQ-035 Bench SHALL cover: no host activity for TIMEOUT_CYC=100 cycles -> link_active 1->0, state IDLE, joy_data=1.
REQ-036 Bench SHALL cover: reset_n pulsed low mid-SHIFT -> all outputs at reset values immediately, without waiting for a clk edge.
REQ-037 Bench SHALL cover, with JOY_DB15_RESP_FILTER_EN defined: a 2-cycle joy_clk glitch -> no shift; a 10-cycle pulse -> one shift, visible 5 cycles after the rising edge.
